mem_arbiter: RTL and testbench

Shares one single-port synchronous data RAM between the CPU data port (its `addressM`/`outM`/`writeM`/`inM` path, stalled via its `stall` input) and a video scan-out requester. A three-state FSM grants one access at a time, drives the RAM from registered signals, and routes read data back with a per-requester acknowledge. Video has fixed priority. An optional starvation guard bounds CPU wait time.

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the CPU data
// port and a video scan-out reader. Three-state FSM (IDLE/ACCESS/RESP), one
// access in flight, registered RAM controls, per-requester ack pulse.
// Video has fixed priority.
// Optional build macro MEM_ARB_STARVE_GUARD_EN adds a 4-bit wait counter:
// after WAIT_LIMIT consecutive lost arbitrations the CPU wins the next one.
module mem_arbiter #(
  parameter int unsigned WAIT_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // CPU data port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  // video scan-out port (read only)
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic [15:0] vid_rdata,
  output logic        vid_ack,
  // RAM side
  output logic        ram_en,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  // Elaboration-time sanity check on the guard threshold.
  if ((WAIT_LIMIT < 1) || (WAIT_LIMIT > 15)) begin : g_bad_limit
    $error("mem_arbiter: WAIT_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        own_q, own_d;          // 0 = CPU, 1 = video
  logic        ram_en_q, ram_en_d;
  logic        ram_we_q, ram_we_d;
  logic [14:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        vid_ack_q, vid_ack_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] vid_rdata_q, vid_rdata_d;

  logic any_req;
  logic guard_fire;  // CPU has waited long enough and overrides video
  logic cpu_win;
  logic grant;       // an arbitration happens on the coming edge

  assign any_req = cpu_req | vid_req;
  assign cpu_win = cpu_req & (~vid_req | guard_fire);
  assign grant   = (state_q == S_IDLE) & any_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

  logic [3:0] wcnt_q, wcnt_d;

  assign guard_fire = cpu_req & (wcnt_q == LIMIT);

  // Wait counter: count CPU losses to video, clear on a CPU win, saturate.
  always_comb begin
    wcnt_d = wcnt_q;
    if (grant) begin
      if (cpu_win)
        wcnt_d = 4'd0;
      else if (cpu_req && (wcnt_q < LIMIT))
        wcnt_d = wcnt_q + 4'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) wcnt_q <= 4'd0;
    else       wcnt_q <= wcnt_d;
  end
`else
  assign guard_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a fixed three-cycle walk once anything is granted; requests
  // are only looked at in IDLE, so the FSM can never wedge on a bad requester.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = any_req ? S_ACCESS : S_IDLE;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: launch the RAM access in IDLE, drop the
  // strobe in ACCESS, steer read data and the ack to the owner in RESP.
  always_comb begin
    own_d       = own_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          own_d    = ~cpu_win;
          ram_en_d = 1'b1;
          // video is read-only, so only a CPU win can raise the write enable
          ram_we_d = cpu_win & cpu_we;
          if (cpu_win) begin
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
          end else begin
            ram_addr_d  = vid_addr;
          end
        end
      end
      S_ACCESS: begin
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
      end
      S_RESP: begin
        // RAM data is valid this cycle; the ack pulse lines up with it
        if (own_q) begin
          vid_rdata_d = ram_rdata;
          vid_ack_d   = 1'b1;
        end else begin
          cpu_rdata_d = ram_rdata;
          cpu_ack_d   = 1'b1;
        end
      end
      default: begin
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and owner; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 15'd0;
      ram_wdata_q <= 16'd0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= 16'd0;
      vid_rdata_q <= 16'd0;
    end else begin
      own_q       <= own_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_rdata = vid_rdata_q;

  // Stall the CPU for as long as it asks and has not been answered.
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random
// phase, all compared every cycle against a transaction-level model
// (arbiter busy countdown, priority rule, reference memory contents).
module tb_mem_arbiter;
  localparam int WL = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [15:0] vid_rdata;
  logic        vid_ack;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_stall(cpu_stall),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
    .vid_ack(vid_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Power-up contents of the RAM, known to both the RAM model and the reference.
  function automatic logic [15:0] init_val(input logic [14:0] a);
    if (a == 15'h4000) return 16'hBEEF;
    return {1'b0, a} ^ 16'hA5A5;
  endfunction

  // Single-port synchronous RAM, read-first.
  logic [15:0] mem [0:32767];
  bit          mem_wr [0:32767];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
      if (ram_we) begin
        mem[ram_addr]    <= ram_wdata;
        mem_wr[ram_addr] <= 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [0:32767];
  bit          ref_wr  [0:32767];
  int          m_busy = 0;      // edges left until the ack shows up
  bit          m_own_vid;
  logic [14:0] m_addr;
  logic [15:0] m_wdata, m_data;
  bit          m_cpu_ack, m_vid_ack, m_ram_en, m_ram_we;
  logic [15:0] m_cpu_rdata, m_vid_rdata;
  int          m_wcnt = 0;

  function automatic logic [15:0] ref_rd(input logic [14:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit cw;
    m_cpu_ack = 0; m_vid_ack = 0; m_ram_en = 0; m_ram_we = 0;
    if (reset) begin
      m_busy = 0; m_cpu_rdata = 0; m_vid_rdata = 0; m_wcnt = 0;
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_own_vid) begin m_vid_ack = 1; m_vid_rdata = m_data; end
        else           begin m_cpu_ack = 1; m_cpu_rdata = m_data; end
      end
    end else if (cpu_req || vid_req) begin
      cw = cpu_req && (!vid_req || (GUARD && m_wcnt == WL));
      if (cw) m_wcnt = 0;
      else if (cpu_req && m_wcnt < WL) m_wcnt++;
      m_own_vid = !cw;
      m_ram_en  = 1;
      m_busy    = 2;
      if (cw) begin
        m_addr  = cpu_addr;
        m_wdata = cpu_wdata;
        m_data  = ref_rd(cpu_addr);
        m_ram_we = cpu_we;
        if (cpu_we) begin ref_mem[cpu_addr] = cpu_wdata; ref_wr[cpu_addr] = 1; end
      end else begin
        m_addr = vid_addr;
        m_data = ref_rd(vid_addr);
      end
    end
  endtask

  task automatic check_all();
    chk("cpu_ack",   cpu_ack,   m_cpu_ack);
    chk("vid_ack",   vid_ack,   m_vid_ack);
    chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
    chk("vid_rdata", vid_rdata, m_vid_rdata);
    chk("ram_en",    ram_en,    m_ram_en);
    chk("ram_we",    ram_we,    m_ram_we);
    if (m_ram_en) begin
      chk("ram_addr", ram_addr, m_addr);
      if (m_ram_we) chk("ram_wdata", ram_wdata, m_wdata);
    end
    chk("cpu_stall", cpu_stall, cpu_req & ~m_cpu_ack);
  endtask

  // Called at a falling edge: cross one rising edge and compare.
  task automatic step();
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic cpu_txn(input logic we, input logic [14:0] a, input logic [15:0] d,
                         output int lat);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_cpu_ack || cpu_ack) begin lat = i; break; end
    end
    chk("cpu_txn_ack", cpu_ack, 1'b1);
    cpu_req = 0;
  endtask

  task automatic vid_txn(input logic [14:0] a);
    vid_req = 1; vid_addr = a;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_vid_ack || vid_ack) break;
    end
    chk("vid_txn_ack", vid_ack, 1'b1);
    vid_req = 0;
  endtask

  function automatic logic [14:0] rnd_addr();
    case ($urandom % 6)
      0: return 15'h0000;
      1: return 15'h0005;
      2: return 15'h4000;
      3: return 15'h7FFF;
      default: return 15'($urandom % 16);
    endcase
  endfunction

  initial begin
    int lat, nc, nv;
    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    vid_req = 0; vid_addr = 0;
    @(negedge clk);
    step(); step();
    chk("rst_ram_addr",  ram_addr,  15'd0);
    chk("rst_ram_wdata", ram_wdata, 16'd0);
    cpu_req = 1; #1;
    chk("rst_stall_follows_req", cpu_stall, 1'b1);
    cpu_req = 0; #1;
    chk("rst_stall_low", cpu_stall, 1'b0);
    step();
    reset = 0;

    // CPU write then read back
    cpu_txn(1'b1, 15'h0005, 16'h1234, lat);
    chk("wr_latency", lat, 2);
    cpu_txn(1'b0, 15'h0005, 16'h0000, lat);
    chk("rd_latency", lat, 2);
    chk("rd_0005", cpu_rdata, 16'h1234);

    // video-only read
    vid_txn(15'h4000);
    chk("vid_beef", vid_rdata, 16'hBEEF);
    chk("cpu_rdata_hold", cpu_rdata, 16'h1234);
    step();

    // reset landing in ACCESS of a CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0007; cpu_wdata = 16'h5A5A;
    step();
    chk("acc_ram_we", ram_we, 1'b1);
    reset = 1; cpu_req = 0;
    step();
    reset = 0;
    chk("rst_mid_en",    ram_en,    1'b0);
    chk("rst_mid_we",    ram_we,    1'b0);
    chk("rst_mid_addr",  ram_addr,  15'd0);
    chk("rst_mid_wdata", ram_wdata, 16'd0);
    chk("rst_mid_rdata", cpu_rdata, 16'd0);
    nc = 0;
    for (int i = 0; i < 4; i++) begin step(); if (cpu_ack) nc++; end
    chk("rst_mid_no_ack", nc, 0);
    cpu_txn(1'b0, 15'h0007, 16'h0000, lat);
    chk("rd_after_rst", cpu_rdata, 16'h5A5A);

    // contention with video held high
    reset = 1; step(); reset = 0;
    vid_req = 1; vid_addr = rnd_addr();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0005;
    nc = 0; nv = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 45; i++) begin
      step();
      if (vid_ack) begin nv++; vid_addr = rnd_addr(); end
      if (cpu_ack) begin chk("guard_run", nv, WL); nv = 0; nc++; end
    end
    chk("guard_cpu_served", nc >= 2, 1'b1);
    vid_req = 0; cpu_req = 0;
`else
    for (int i = 0; i < 40; i++) begin
      step();
      if (cpu_ack) nc++;
      if (vid_ack) vid_addr = rnd_addr();
      if (i >= 20 && vid_ack) break;
    end
    chk("starve_cpu", nc, 0);
    vid_req = 0;
    nc = -1;
    for (int i = 0; i < 10; i++) begin step(); if (cpu_ack) begin nc = i; break; end end
    chk("starve_release", nc, 2);
    cpu_req = 0;
`endif
    for (int i = 0; i < 3; i++) step();

    // random phase
    for (int i = 0; i < 800; i++) begin
      step();
      reset = (($urandom % 80) == 0);
      if (cpu_req && m_cpu_ack) begin
        if ($urandom % 2) begin
          cpu_we = $urandom % 2; cpu_addr = rnd_addr(); cpu_wdata = 16'($urandom);
        end else cpu_req = 0;
      end else if (!cpu_req && ($urandom % 3 == 0)) begin
        cpu_req = 1; cpu_we = $urandom % 2; cpu_addr = rnd_addr(); cpu_wdata = 16'($urandom);
      end
      if (vid_req && m_vid_ack) begin
        if ($urandom % 2) vid_addr = rnd_addr();
        else vid_req = 0;
      end else if (!vid_req && ($urandom % 4 == 0)) begin
        vid_req = 1; vid_addr = rnd_addr();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
